mmio_timer_bank: RTL and testbench
==================================

# mmio_timer_bank

Memory-mapped bank of `NUM_CH` independent reload timers on the CPU data bus, alongside the LED, switch, digit and UART registers. Each channel has a reload value, a live counter, auto-reload or one-shot mode, a per-channel prescaler and a maskable overflow flag. All enabled channel interrupts are ORed onto one `irqout` line. The bank replaces the single fixed 32-bit timer with a parametrised one.

## Interface
- `BASE_ADDR`, default 32'h40000100: byte address of channel 0, word aligned.
- `NUM_CH`, default 4: number of channels, 1..8.
- `CNT_W`, default 32: counter and reload width, 8..32.
- `clk`  in  1: system clock. This is the one clock; all logic is on its rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `MemRead`  in  1: bus read strobe.
- `MemWrite`  in  1: bus write strobe.
- `Address`  in  32: byte address.
- `Write_data`  in  32: write data.
- `Read_data`  out  32: read data (combinational).
- `irqout`  out  1: OR of `flag & irq_en` over all channels (combinational from registers).

## Operation
- Channel `i` register block starts at `BASE_ADDR + 16*i`:
  - +0 `TH`: reload value, R/W, `CNT_W` bits.
  - +4 `TL`: live counter, R/W.
  - +8 `CTRL`, one bit per function:
    - [0] `en`: enable, R/W.
    - [1] `irq_en`: interrupt enable, R/W.
    - [2] `flag`: overflow flag, R; writing 1 clears it, writing 0 has no effect.
    - [3] `oneshot`: mode select, R/W.
  - +C `PRE`: prescaler, R/W, 16 bits.
- `STATUS` at `BASE_ADDR + 16*NUM_CH`:
  - Bits [NUM_CH-1:0] read back all flags.
  - Writing 1 to a bit clears that channel's flag.
- Address decode:
  - Exact 32-bit match only.
  - Unmapped addresses read 0 and ignore writes.
  - Unused upper bits of every register read 0 and are ignored on write.
- Reads:
  - When `MemRead`=0, `Read_data`=0.
  - Reads have no side effects.
- Prescaler:
  - Each channel has an internal `pre_cnt` (16 bits).
  - While `en`=1, each cycle either increments `pre_cnt` or, if `pre_cnt==PRE`, clears it and issues one tick.
  - `pre_cnt` is forced to 0 while `en`=0 and on any write to that channel's `PRE`.
- Each tick:
  - If `TL` is all ones (`CNT_W` bits), the tick is an overflow:
    - `TL <= TH` and `flag <= 1`.
    - If `oneshot`=1, `en <= 0`.
  - Otherwise, `TL <= TL+1`.
- Overflow period is (2^CNT_W − TH) ticks.
- `flag` is set on every overflow regardless of `irq_en`. `irq_en` only masks `irqout`.
- Simultaneous events:
  - Software write to `TL` or `TH` in the same cycle as a tick: the software write wins and the tick is dropped.
  - Write-1-to-clear of `flag` in the same cycle as an overflow: the set wins and `flag`=1.
  - A `CTRL` write with `en`=0 in the same cycle as an overflow: `en`=0, and the reload still happens.
  - Any write to `CTRL` updates `en`, `irq_en` and `oneshot` together.
- Reset, applied at any time including mid-count:
  - All `TH`, `TL`, `CTRL`, `PRE` and `pre_cnt` = 0.
  - `Read_data`=0 (MemRead is low during reset), `irqout`=0.

## Timing
- A write is visible on a read starting the cycle after the write edge.
- Enabling:
  - The edge that writes `en`=1 performs no count.
  - With `PRE`=0, the first increment occurs on the next edge.
  - After that, `TL` increments every cycle.
- With `PRE`=P, a tick occurs every P+1 cycles. The first tick falls P+1 edges after the enabling edge.
- `flag` and `irqout` rise the cycle after the overflow edge, i.e. they are registered flag outputs with no extra delay.
- In one-shot mode, `en` reads 0 from the cycle after overflow.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - `PRE` registers and `pre_cnt` are implemented as described above.
- `TIMER_PRESCALE_EN` not defined:
  - No prescaler logic is built.
  - `PRE` reads 0 and ignores writes.
  - Every cycle with `en`=1 is a tick.

## Test plan
- **Reset:** NUM_CH=4, CNT_W=32; pulse reset mid-count → every register reads 0 and `irqout`=0 on the next cycle.
- **Auto-reload:** TH=FFFFFFFC, TL=FFFFFFFC, CTRL=3, PRE=0 → flag=1 and irqout=1 exactly 4 cycles after the enabling edge, TL=FFFFFFFC; with flag cleared, the next overflow follows 4 cycles later.
- **One-shot:**
  - Channel 2 with TH=0, TL=FFFFFFFE, CTRL=9 (en + oneshot) → overflow after 2 cycles; TL=0 and en=0 afterwards; TL holds 0 for 10 more cycles.
  - irqout stays 0 (irq_en=0) while STATUS[2]=1.
- **Prescale** (TIMER_PRESCALE_EN defined): PRE=3, TL=0, en=1 → TL=1 after 4 cycles and TL=5 after 20 cycles. With the macro undefined, the same stimulus gives TL=20 after 20 cycles and PRE reads 0.
- **Collisions:**
  - Write 1 to `STATUS[0]` in the same cycle as a channel 0 overflow → flag stays 1.
  - Write TL=5 in the same cycle as a tick → TL reads 5.
- **Decode:** write to `BASE_ADDR+16*NUM_CH+4` and to `BASE_ADDR+2` → no register changes, and both addresses read 0.

Source files
------------

// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of NUM_CH reload timers with a shared interrupt line.
// Define TIMER_PRESCALE_EN to build the per-channel 16-bit prescalers.
module mmio_timer_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100,
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irqout
);

    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'(16 * NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] th_q [NUM_CH];
    logic [CNT_W-1:0] th_d [NUM_CH];
    logic [CNT_W-1:0] tl_q [NUM_CH];
    logic [CNT_W-1:0] tl_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] ie_q, ie_d;
    logic [NUM_CH-1:0] flag_q, flag_d;
    logic [NUM_CH-1:0] os_q, os_d;

    logic [NUM_CH-1:0] wr_th, wr_tl, wr_ctl;
    logic [NUM_CH-1:0] tick;
    logic              wr_stat;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] pre_q  [NUM_CH];
    logic [15:0] pre_d  [NUM_CH];
    logic [15:0] pcnt_q [NUM_CH];
    logic [15:0] pcnt_d [NUM_CH];
    logic [NUM_CH-1:0] wr_pre;
`endif

    function automatic logic [31:0] reg_addr(input int ch, input int off);
        return BASE_ADDR + 32'(16 * ch + off);
    endfunction

    always_comb begin
        wr_stat = MemWrite && (Address == STAT_ADDR);
        wr_th   = '0;
        wr_tl   = '0;
        wr_ctl  = '0;
`ifdef TIMER_PRESCALE_EN
        wr_pre  = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            wr_th[i]  = MemWrite && (Address == reg_addr(i, 0));
            wr_tl[i]  = MemWrite && (Address == reg_addr(i, 4));
            wr_ctl[i] = MemWrite && (Address == reg_addr(i, 8));
`ifdef TIMER_PRESCALE_EN
            wr_pre[i] = MemWrite && (Address == reg_addr(i, 12));
`endif
        end
    end

`ifdef TIMER_PRESCALE_EN
    // A tick fires on the cycle the prescale count reaches PRE.
    always_comb begin
        tick = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pre_d[i]  = wr_pre[i] ? Write_data[15:0] : pre_q[i];
            tick[i]   = en_q[i] && (pcnt_q[i] == pre_q[i]);
            pcnt_d[i] = pcnt_q[i] + 16'd1;
            if (!en_q[i] || wr_pre[i] || tick[i]) begin
                pcnt_d[i] = '0;
            end
        end
    end
`else
    always_comb begin
        tick = en_q;
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            th_d[i] = th_q[i];
            tl_d[i] = tl_q[i];
        end
        en_d   = en_q;
        ie_d   = ie_q;
        flag_d = flag_q;
        os_d   = os_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((wr_ctl[i] && Write_data[2]) || (wr_stat && Write_data[i])) begin
                flag_d[i] = 1'b0;
            end
            // Software writes to TH/TL swallow a coincident tick.
            if (tick[i] && !wr_th[i] && !wr_tl[i]) begin
                if (tl_q[i] == CNT_MAX) begin
                    tl_d[i]   = th_q[i];
                    flag_d[i] = 1'b1;
                    if (os_q[i]) begin
                        en_d[i] = 1'b0;
                    end
                end else begin
                    tl_d[i] = tl_q[i] + CNT_W'(1);
                end
            end
            if (wr_th[i]) begin
                th_d[i] = Write_data[CNT_W-1:0];
            end
            if (wr_tl[i]) begin
                tl_d[i] = Write_data[CNT_W-1:0];
            end
            if (wr_ctl[i]) begin
                en_d[i] = Write_data[0];
                ie_d[i] = Write_data[1];
                os_d[i] = Write_data[3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                th_q[i] <= '0;
                tl_q[i] <= '0;
`ifdef TIMER_PRESCALE_EN
                pre_q[i]  <= '0;
                pcnt_q[i] <= '0;
`endif
            end
            en_q   <= '0;
            ie_q   <= '0;
            flag_q <= '0;
            os_q   <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
`ifdef TIMER_PRESCALE_EN
            pre_q  <= pre_d;
            pcnt_q <= pcnt_d;
`endif
            en_q   <= en_d;
            ie_q   <= ie_d;
            flag_q <= flag_d;
            os_q   <= os_d;
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (Address == STAT_ADDR) begin
                Read_data[NUM_CH-1:0] = flag_q;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (Address == reg_addr(i, 0)) begin
                    Read_data = 32'(th_q[i]);
                end
                if (Address == reg_addr(i, 4)) begin
                    Read_data = 32'(tl_q[i]);
                end
                if (Address == reg_addr(i, 8)) begin
                    Read_data = {28'd0, os_q[i], flag_q[i], ie_q[i], en_q[i]};
                end
`ifdef TIMER_PRESCALE_EN
                if (Address == reg_addr(i, 12)) begin
                    Read_data = {16'd0, pre_q[i]};
                end
`endif
            end
        end
    end

    assign irqout = |(flag_q & ie_q);

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Randomized and directed bench for mmio_timer_bank against a reference model.
// Honours TIMER_PRESCALE_EN the same way the design does.
module tb_mmio_timer_bank;

    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam logic [31:0] STAT = BASE + 32'h40;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        irqout;

    int n_vec = 0;
    int n_err = 0;

    mmio_timer_bank #(
        .BASE_ADDR(BASE),
        .NUM_CH(NCH),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .Address(Address),
        .Write_data(Write_data),
        .Read_data(Read_data),
        .irqout(irqout)
    );

    always #5 clk = ~clk;

    // Reference state: one entry per channel.
    logic [31:0] m_th [NCH];
    logic [31:0] m_tl [NCH];
    bit          m_en [NCH];
    bit          m_ie [NCH];
    bit          m_fl [NCH];
    bit          m_os [NCH];
    int unsigned m_pre [NCH];
    int unsigned m_pc  [NCH];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_th[c] = 0; m_tl[c] = 0; m_en[c] = 0; m_ie[c] = 0;
            m_fl[c] = 0; m_os[c] = 0; m_pre[c] = 0; m_pc[c] = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r = '0;
        if (a == STAT) begin
            for (int c = 0; c < NCH; c++) r[c] = m_fl[c];
        end
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] b = BASE + 32'(16 * c);
            if (a == b)      r = m_th[c];
            if (a == b + 4)  r = m_tl[c];
            if (a == b + 8)  r = {28'd0, m_os[c], m_fl[c], m_ie[c], m_en[c]};
`ifdef TIMER_PRESCALE_EN
            if (a == b + 12) r = m_pre[c];
`endif
        end
        return r;
    endfunction

    function automatic logic m_irq();
        logic v = 1'b0;
        for (int c = 0; c < NCH; c++) v |= m_fl[c] & m_ie[c];
        return v;
    endfunction

    // One clock edge of the timer bank behaviour.
    task automatic model_edge(input bit we, input logic [31:0] a,
                              input logic [31:0] d);
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] b = BASE + 32'(16 * c);
            bit h_th = we && (a == b);
            bit h_tl = we && (a == b + 4);
            bit h_ct = we && (a == b + 8);
            bit h_pr = we && (a == b + 12);
            bit tk;
`ifdef TIMER_PRESCALE_EN
            tk = m_en[c] && (m_pc[c] == m_pre[c]);
            m_pc[c] = (!m_en[c] || h_pr) ? 0 : (m_pc[c] + 1) % (m_pre[c] + 1);
            if (h_pr) m_pre[c] = d & 32'h0000_FFFF;
`else
            tk = m_en[c];
            if (h_pr) m_pc[c] = 0;
`endif
            if ((h_ct && d[2]) || (we && a == STAT && d[c])) m_fl[c] = 0;
            if (tk && !h_th && !h_tl) begin
                if (m_tl[c] == 32'hFFFF_FFFF) begin
                    m_tl[c] = m_th[c];
                    m_fl[c] = 1;
                    if (m_os[c]) m_en[c] = 0;
                end else begin
                    m_tl[c] = m_tl[c] + 1;
                end
            end
            if (h_th) m_th[c] = d;
            if (h_tl) m_tl[c] = d;
            if (h_ct) begin
                m_en[c] = d[0];
                m_ie[c] = d[1];
                m_os[c] = d[3];
            end
        end
    endtask

    task automatic bus_cycle(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] q);
        @(negedge clk);
        MemRead = rd;
        MemWrite = wr;
        Address = a;
        Write_data = d;
        #1;
        q = Read_data;
        chk("rdata", Read_data, rd ? m_read(a) : 32'd0);
        chk("irqout", {31'd0, irqout}, {31'd0, m_irq()});
        @(posedge clk);
        model_edge(wr, a, d);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_cycle(0, 1, a, d, q);
    endtask

    task automatic idle(input int n);
        logic [31:0] q;
        for (int k = 0; k < n; k++) bus_cycle(0, 0, 32'd0, 32'd0, q);
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        logic [31:0] q;
        bus_cycle(1, 0, a, 32'd0, q);
        chk(tag, q, exp);
    endtask

    task automatic read_all();
        logic [31:0] q;
        for (int k = 0; k <= 4 * NCH; k++) begin
            bus_cycle(1, 0, BASE + 32'(4 * k), 32'd0, q);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        #1;
        chk("irq_pre_rst", {31'd0, irqout}, {31'd0, m_irq()});
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-count
        wr(BASE + 4, 32'hFFFF_FFF0);
        wr(BASE + 8, 32'h3);
        idle(20);
        do_reset();
        rd_exp("rst_irq_ctl0", BASE + 8, 32'd0);
        rd_exp("rst_tl0", BASE + 4, 32'd0);
        read_all();

        // Auto-reload
        do_reset();
        wr(BASE + 0, 32'hFFFF_FFFC);
        wr(BASE + 4, 32'hFFFF_FFFC);
        wr(BASE + 12, 32'd0);
        wr(BASE + 8, 32'h3);
        idle(4);
        rd_exp("ar_tl", BASE + 4, 32'hFFFF_FFFC);
        rd_exp("ar_ctl", BASE + 8, 32'h7);
        wr(STAT, 32'h1);
        rd_exp("ar_clr", BASE + 8, 32'h3);
        idle(1);
        rd_exp("ar_again", BASE + 8, 32'h7);

        // One-shot on channel 2
        do_reset();
        wr(BASE + 32'h20, 32'd0);
        wr(BASE + 32'h24, 32'hFFFF_FFFE);
        wr(BASE + 32'h28, 32'h9);
        idle(2);
        rd_exp("os_ctl", BASE + 32'h28, 32'hC);
        idle(10);
        rd_exp("os_tl", BASE + 32'h24, 32'd0);
        rd_exp("os_stat", STAT, 32'h4);

        // Prescale on channel 1
        do_reset();
        wr(BASE + 32'h1C, 32'd3);
        wr(BASE + 32'h14, 32'd0);
        wr(BASE + 32'h18, 32'h1);
        idle(20);
`ifdef TIMER_PRESCALE_EN
        rd_exp("pre_tl", BASE + 32'h14, 32'd5);
        rd_exp("pre_reg", BASE + 32'h1C, 32'd3);
`else
        rd_exp("pre_tl", BASE + 32'h14, 32'd20);
        rd_exp("pre_reg", BASE + 32'h1C, 32'd0);
`endif

        // Collisions
        do_reset();
        wr(BASE + 4, 32'hFFFF_FFFE);
        wr(BASE + 8, 32'h1);
        idle(1);
        wr(STAT, 32'h1);
        rd_exp("col_flag", BASE + 8, 32'h5);
        wr(BASE + 4, 32'd5);
        rd_exp("col_tl", BASE + 4, 32'd5);

        // Decode
        do_reset();
        wr(STAT + 4, 32'hFFFF_FFFF);
        wr(BASE + 2, 32'hFFFF_FFFF);
        rd_exp("dec_a", STAT + 4, 32'd0);
        rd_exp("dec_b", BASE + 2, 32'd0);
        read_all();

        // Random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int k = $urandom_range(0, 19);
            int op = $urandom_range(0, 9);
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] q;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            case (k)
                16: a = STAT;
                17: a = BASE + 2;
                18: a = STAT + 4;
                19: a = BASE - 4;
                default: a = BASE + 32'(16 * (k / 4) + 4 * (k % 4));
            endcase
            d = $urandom;
            if (k < 16) begin
                case (k % 4)
                    0: if ($urandom_range(0, 1) == 1)
                           d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    1: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 12));
                    3: d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                    default: d = $urandom;
                endcase
            end
            if (op < 4) bus_cycle(0, 0, a, d, q);
            else if (op < 7) bus_cycle(1, 0, a, 32'd0, q);
            else bus_cycle(0, 1, a, d, q);
        end
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
